// File: rtl/joystick_conditioner.sv
// Conditions two active-low joystick ports: synchronise, debounce on a slow tick,
// cancel opposing directions, gate fire1 with autofire, and emit Kempston bytes.
module joystick_conditioner #(
  parameter int unsigned TICK_DIV       = 1389,
  parameter int unsigned DEBOUNCE_TICKS = 8,
  parameter int unsigned AUTOFIRE_TICKS = 40
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [5:0] joy1_raw_i,
  input  logic [5:0] joy2_raw_i,
  input  logic       autofire1_en_i,
  input  logic       autofire2_en_i,
  output logic [7:0] joy1_o,
  output logic [7:0] joy2_o,
  output logic       changed_o
);

  localparam int unsigned NB = 12;
  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int unsigned AW = (AUTOFIRE_TICKS > 1) ? $clog2(AUTOFIRE_TICKS) : 1;

  logic [NB-1:0]         sync1_q;
  logic [NB-1:0]         sync2_q;
  logic [TW-1:0]         tick_cnt_q;
  logic                  tick;
  logic [NB-1:0]         stable_q;
  logic [NB-1:0][CW-1:0] db_cnt_q;
  logic [1:0]            af_phase_q;
  logic [1:0][AW-1:0]    af_cnt_q;
  logic [1:0]            af_en;
  logic [1:0]            f1_pressed;
  logic [7:0]            joy1_nxt;
  logic [7:0]            joy2_nxt;

  // Two-flop synchroniser; reset value is "released" (high).
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= {joy2_raw_i, joy1_raw_i};
      sync2_q <= sync1_q;
    end
  end

  // Sample tick generator.
  assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + TW'(1);
    end
  end

  // Per-line debounce: a new level needs DEBOUNCE_TICKS consecutive disagreeing ticks.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stable_q <= '1;
      db_cnt_q <= '0;
    end else if (tick) begin
      for (int i = 0; i < int'(NB); i++) begin
        if (sync2_q[i] != stable_q[i]) begin
          if (db_cnt_q[i] == CW'(DEBOUNCE_TICKS - 1)) begin
            stable_q[i] <= sync2_q[i];
            db_cnt_q[i] <= '0;
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + CW'(1);
          end
        end else begin
          db_cnt_q[i] <= '0;
        end
      end
    end
  end

  assign af_en      = {autofire2_en_i, autofire1_en_i};
  assign f1_pressed = {~stable_q[10], ~stable_q[4]};

  // Autofire: phase starts high so the first press fires at once.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      af_phase_q <= '1;
      af_cnt_q   <= '0;
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (f1_pressed[j] && af_en[j]) begin
          if (tick) begin
            if (af_cnt_q[j] == AW'(AUTOFIRE_TICKS - 1)) begin
              af_phase_q[j] <= ~af_phase_q[j];
              af_cnt_q[j]   <= '0;
            end else begin
              af_cnt_q[j] <= af_cnt_q[j] + AW'(1);
            end
          end
        end else begin
          af_phase_q[j] <= 1'b1;
          af_cnt_q[j]   <= '0;
        end
      end
    end
  end

  // Pressed levels (active high, U/D/L/R/F1/F2) to Kempston with opposing-direction cancel.
  function automatic logic [7:0] kempston(input logic [5:0] pr, input logic f1_gate);
    logic up;
    logic dn;
    logic lf;
    logic rt;
    up = pr[0] & ~pr[1];
    dn = pr[1] & ~pr[0];
    lf = pr[2] & ~pr[3];
    rt = pr[3] & ~pr[2];
    return {2'b00, pr[5], pr[4] & f1_gate, up, dn, lf, rt};
  endfunction

  always_comb begin
    joy1_nxt = kempston(~stable_q[5:0],  af_en[0] ? af_phase_q[0] : 1'b1);
    joy2_nxt = kempston(~stable_q[11:6], af_en[1] ? af_phase_q[1] : 1'b1);
  end

  // Output register and change strobe.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      joy1_o    <= '0;
      joy2_o    <= '0;
      changed_o <= 1'b0;
    end else begin
      joy1_o    <= joy1_nxt;
      joy2_o    <= joy2_nxt;
      changed_o <= (joy1_nxt != joy1_o) || (joy2_nxt != joy2_o);
    end
  end

endmodule

// File: tb/tb_joystick_conditioner.sv
// Scoreboard bench for joystick_conditioner: expected output changes are queued with
// latency windows and checked by a monitor whenever changed_o pulses.
module tb_joystick_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] joy1_raw;
  logic [5:0] joy2_raw;
  logic       af1_en;
  logic       af2_en;
  logic [7:0] joy1;
  logic [7:0] joy2;
  logic       changed;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_pulse = 0;

  typedef struct {
    logic [7:0] j1;
    logic [7:0] j2;
    int         base;
    bit         rel;
    int         lo;
    int         hi;
  } exp_t;

  exp_t sb[$];

  joystick_conditioner #(
    .TICK_DIV(4), .DEBOUNCE_TICKS(3), .AUTOFIRE_TICKS(2)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .joy1_raw_i(joy1_raw), .joy2_raw_i(joy2_raw),
    .autofire1_en_i(af1_en), .autofire2_en_i(af2_en),
    .joy1_o(joy1), .joy2_o(joy2), .changed_o(changed)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every changed_o pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && changed) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_change: cyc=%0d joy1=%02h joy2=%02h", cyc, joy1, joy2);
      end else begin
        exp_t e;
        int   lat;
        e   = sb.pop_front();
        lat = cyc - (e.rel ? last_pulse : e.base);
        total++;
        if (joy1 !== e.j1 || joy2 !== e.j2) begin
          bad++;
          $display("FAIL out_value: got %02h/%02h want %02h/%02h", joy1, joy2, e.j1, e.j2);
        end
        total++;
        if (lat < e.lo || lat > e.hi) begin
          bad++;
          $display("FAIL out_latency: got %0d want %0d..%0d", lat, e.lo, e.hi);
        end
      end
      last_pulse = cyc;
    end
  end

  task automatic expect_out(input logic [7:0] j1, input logic [7:0] j2,
                            input bit rel, input int lo, input int hi);
    exp_t e;
    e.j1 = j1; e.j2 = j2; e.base = cyc; e.rel = rel; e.lo = lo; e.hi = hi;
    sb.push_back(e);
  endtask

  task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h want %02h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait for all queued expectations to be consumed, bounded.
  task automatic drain(input string nm, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk);
      #2;
      if (sb.size() == 0) done = 1'b1;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s_timeout: got %0d pending want 0", nm, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    af1_en   = 1'b0;
    af2_en   = 1'b0;
    joy1_raw = '1;
    joy2_raw = '1;

    // Reset with random inputs
    for (int k = 0; k < 3; k++) begin
      joy1_raw = 6'($urandom);
      joy2_raw = 6'($urandom);
      af1_en   = 1'($urandom);
      af2_en   = 1'($urandom);
      idle(2);
      check8("rst_joy1", joy1, 8'h00);
      check8("rst_joy2", joy2, 8'h00);
      check8("rst_changed", {7'd0, changed}, 8'h00);
    end
    joy1_raw = '1;
    joy2_raw = '1;
    af1_en   = 1'b0;
    af2_en   = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(30);
    check8("idle_joy1", joy1, 8'h00);
    check8("idle_joy2", joy2, 8'h00);

    // Press and release joy1 up
    joy1_raw = 6'b111110;
    expect_out(8'h08, 8'h00, 1'b0, 11, 15);
    drain("press_up", 40);
    joy1_raw = 6'b111111;
    expect_out(8'h00, 8'h00, 1'b0, 11, 15);
    drain("release_up", 40);

    // Bounce: two-tick glitch on joy2 fire1 is rejected
    joy2_raw = 6'b101111;
    idle(8);
    joy2_raw = 6'b111111;
    idle(30);
    check8("bounce_joy2", joy2, 8'h00);
    joy2_raw = 6'b101111;
    expect_out(8'h00, 8'h10, 1'b0, 11, 15);
    drain("press_f1_j2", 40);
    joy2_raw = 6'b111111;
    expect_out(8'h00, 8'h00, 1'b0, 11, 15);
    drain("release_f1_j2", 40);

    // Opposing directions cancel
    joy1_raw = 6'b111100;
    idle(25);
    check8("socd_ud", joy1, 8'h00);
    joy1_raw = 6'b111000;
    expect_out(8'h02, 8'h00, 1'b0, 11, 15);
    drain("socd_udl", 40);
    joy1_raw = 6'b111111;
    expect_out(8'h00, 8'h00, 1'b0, 11, 15);
    drain("socd_release", 40);

    // Autofire on joy1 fire1
    af1_en   = 1'b1;
    idle(2);
    joy1_raw = 6'b101111;
    expect_out(8'h10, 8'h00, 1'b0, 11, 15);
    expect_out(8'h00, 8'h00, 1'b1, 8, 8);
    expect_out(8'h10, 8'h00, 1'b1, 8, 8);
    expect_out(8'h00, 8'h00, 1'b1, 8, 8);
    drain("autofire", 60);
    check8("af_low_phase", joy1, 8'h00);
    af1_en = 1'b0;
    expect_out(8'h10, 8'h00, 1'b0, 1, 1);
    drain("af_disable", 5);
    idle(20);
    check8("af_steady", joy1, 8'h10);
    joy1_raw = 6'b111111;
    expect_out(8'h00, 8'h00, 1'b0, 11, 15);
    drain("af_release", 40);

    // Async reset mid-debounce discards the partial count
    joy1_raw = 6'b111110;
    idle(10);
    rst_n = 1'b0;
    #1;
    check8("midrst_joy1", joy1, 8'h00);
    check8("midrst_changed", {7'd0, changed}, 8'h00);
    idle(3);
    rst_n = 1'b1;
    expect_out(8'h08, 8'h00, 1'b0, 11, 15);
    drain("post_rst_press", 40);
    joy1_raw = 6'b111111;
    expect_out(8'h00, 8'h00, 1'b0, 11, 15);
    drain("post_rst_release", 40);

    idle(10);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL pending_at_end: got %0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
